// File: rtl/bus_host.sv
// rtl/bus_host.sv - bus transfer initiator: burst write, readback request, compare and report
module bus_host #(
  parameter int n = 8,
  parameter int size = 1024,
  localparam int LW = $clog2(size + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [LW-1:0] cmd_len,
  input  logic [n-1:0]  cmd_seed,
  output logic          start,
  output logic          stop,
  output logic [n-1:0]  datain,
  output logic          start_read,
  input  logic [n-1:0]  dataout,
  input  logic          buff_full,
  input  logic          buff_empty,
  output logic          done,
  output logic [LW-1:0] err_count,
  output logic          overflow
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    GAP,
    READ_REQ,
    READ_WAIT,
    READ,
    DONE
  } state_t;

  state_t        state;
  logic [LW-1:0] len_q;
  logic [n-1:0]  seed_q;
  logic [LW-1:0] idx;
  logic [n-1:0]  expected;
  logic          last;
  logic          unused_empty;

  // One index serves both the write word counter and the readback counter;
  // the expected word wraps modulo 2^n because the sum is n bits wide.
  assign expected     = seed_q + n'(idx);
  assign last         = (idx == len_q - LW'(1));
  assign unused_empty = buff_empty;

  // Burst sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      start      <= 1'b0;
      stop       <= 1'b0;
      start_read <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      datain     <= '0;
      err_count  <= '0;
      len_q      <= '0;
      seed_q     <= '0;
      idx        <= '0;
    end else begin
      done       <= 1'b0;
      start_read <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            len_q     <= cmd_len;
            seed_q    <= cmd_seed;
            idx       <= '0;
            err_count <= '0;
            overflow  <= 1'b0;
            state     <= (cmd_len == '0) ? DONE : WRITE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (buff_full) begin
            // Abort cycle: datain keeps the last presented word.
            start    <= 1'b0;
            stop     <= 1'b1;
            overflow <= 1'b1;
            state    <= DONE;
          end else begin
            datain <= expected;
            start  <= (idx == '0);
            stop   <= last;
            idx    <= idx + LW'(1);
            if (last) state <= GAP;
          end
        end
        GAP: begin
          start <= 1'b0;
          stop  <= 1'b0;
          state <= READ_REQ;
        end
        READ_REQ: begin
          start_read <= 1'b1;
          idx        <= '0;
          state      <= READ_WAIT;
        end
        READ_WAIT: begin
          // The device samples the request on this edge and drives word 0 after it.
          state <= READ;
        end
        READ: begin
          if (dataout != expected && err_count != LW'(size)) begin
            err_count <= err_count + LW'(1);
          end
          idx <= idx + LW'(1);
          if (last) state <= DONE;
        end
        DONE: begin
          start <= 1'b0;
          stop  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_host.sv
// tb/tb_bus_host.sv - self-checking bench for bus_host with a buffering device model
module tb_bus_host;

  localparam int N    = 8;
  localparam int SIZE = 1024;
  localparam int LW   = $clog2(SIZE + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic [N-1:0]  cmd_seed;
  logic          start;
  logic          stop;
  logic [N-1:0]  datain;
  logic          start_read;
  logic [N-1:0]  dataout = '0;
  logic          buff_full;
  logic          buff_empty;
  logic          done;
  logic [LW-1:0] err_count;
  logic          overflow;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  bus_host #(.n(N), .size(SIZE)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_seed   (cmd_seed),
    .start      (start),
    .stop       (stop),
    .datain     (datain),
    .start_read (start_read),
    .dataout    (dataout),
    .buff_full  (buff_full),
    .buff_empty (buff_empty),
    .done       (done),
    .err_count  (err_count),
    .overflow   (overflow)
  );

  // Device model: store written words, replay them after a readback request
  logic [N-1:0] mem[$];
  bit           wr_on    = 1'b0;
  bit           rd_on    = 1'b0;
  int           rd_ptr   = 0;
  int           flip_idx = -1;

  // Device write side samples on the falling edge
  always @(negedge clock) begin
    if (start) begin
      mem.delete();
      mem.push_back(datain);
      wr_on = !stop;
    end else if (wr_on) begin
      mem.push_back(datain);
      if (stop) wr_on = 1'b0;
    end
  end

  // Device read side: request seen at an edge, word 0 driven just after it
  always @(posedge clock) begin
    if (start_read) begin
      rd_ptr = 0;
      rd_on  = 1'b1;
    end else if (rd_on) begin
      rd_ptr++;
    end
    #1;
    if (rd_on && rd_ptr < mem.size()) dataout = (rd_ptr == flip_idx) ? ~mem[rd_ptr] : mem[rd_ptr];
  end

  // Observations of the last burst
  logic [N-1:0] wr_q[$];
  int           obs_done_cycle;
  int           obs_done_count;
  int           obs_sr_count;
  bit           obs_both;
  logic [N-1:0] last_data = '0;

  // Issue one command and follow it cycle by cycle against the protocol rules.
  task automatic run_burst(input int len, input logic [N-1:0] seed, input int flip, input int abort_at);
    bit           ab;
    int           end_c, w, guard, exp_err;
    logic [N-1:0] exp_d;
    logic [4:0]   e_str;
    ab      = (len > 0) && (abort_at >= 1) && (abort_at <= len);
    end_c   = (len == 0) ? 1 : (ab ? abort_at + 1 : 2 * len + 4);
    w       = ab ? abort_at - 1 : len;
    exp_err = (!ab && len > 0 && flip >= 0 && flip < len) ? 1 : 0;
    flip_idx = flip;
    wr_q.delete();
    obs_done_cycle = -1;
    obs_done_count = 0;
    obs_sr_count   = 0;
    obs_both       = 1'b0;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 40) begin
      @(posedge clock); #2;
      guard++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    cmd_seed  = seed;
    @(posedge clock); #2;
    cmd_valid = 1'b0;
    cmd_len   = LW'($urandom_range(0, SIZE));
    cmd_seed  = N'($urandom);
    for (int c = 1; c <= end_c + 1; c++) begin
      if (ab && c == abort_at) buff_full = 1'b1;
      @(posedge clock); #2;
      buff_full = 1'b0;
      e_str[4] = (c == 1) && (w >= 1);
      e_str[3] = (!ab && len > 0 && c == len) || (ab && c == abort_at);
      e_str[2] = !ab && len > 0 && c == len + 2;
      e_str[1] = (c == end_c);
      e_str[0] = (c == end_c + 1);
      vectors++;
      if ({start, stop, start_read, done, cmd_ready} !== e_str) begin
        miscompares++;
        $display("FAIL strobes len=%0d c=%0d: got start,stop,start_read,done,cmd_ready=%b want %b",
                 len, c, {start, stop, start_read, done, cmd_ready}, e_str);
      end
      if (c <= w || (ab && c == abort_at)) begin
        exp_d = (c <= w) ? seed + N'(c - 1) : last_data;
        vectors++;
        if (datain !== exp_d) begin
          miscompares++;
          $display("FAIL datain len=%0d c=%0d: got %h want %h", len, c, datain, exp_d);
        end
        wr_q.push_back(datain);
        last_data = exp_d;
      end
      if (start && stop) obs_both = 1'b1;
      if (start_read) obs_sr_count++;
      if (done) begin
        obs_done_count++;
        if (obs_done_cycle < 0) obs_done_cycle = c;
      end
      if (c == end_c) begin
        vectors++;
        if (err_count !== LW'(exp_err) || overflow !== ab) begin
          miscompares++;
          $display("FAIL result len=%0d: got err_count=%0d overflow=%b want %0d %b",
                   len, err_count, overflow, exp_err, ab);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clock); #2;
    end
    vectors++;
    if ({start, stop, start_read, done, overflow, cmd_ready} !== 6'b000001 || datain !== '0 || err_count !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got strobes=%b datain=%h err=%0d want 000001 00 0",
               {start, stop, start_read, done, overflow, cmd_ready}, datain, err_count);
    end
    reset = 1'b0;
    last_data = '0;
  endtask

  task automatic test_basic();
    logic [N-1:0] e[4];
    e = '{8'h10, 8'h11, 8'h12, 8'h13};
    run_burst(4, 8'h10, -1, 0);
    vectors++;
    if (wr_q.size() != 4 || obs_done_cycle != 12 || obs_sr_count != 1) begin
      miscompares++;
      $display("FAIL basic_shape: got words=%0d done_cycle=%0d start_reads=%0d want 4 12 1",
               wr_q.size(), obs_done_cycle, obs_sr_count);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (wr_q[i] !== e[i]) begin
          miscompares++;
          $display("FAIL basic_word%0d: got %h want %h", i, wr_q[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_single_wrap();
    logic [N-1:0] e[3];
    e = '{8'hFE, 8'hFF, 8'h00};
    run_burst(1, 8'h7F, -1, 0);
    vectors++;
    if (obs_both !== 1'b1 || err_count !== '0) begin
      miscompares++;
      $display("FAIL single_word: got start&stop=%b err=%0d want 1 0", obs_both, err_count);
    end
    run_burst(3, 8'hFE, -1, 0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (wr_q.size() != 3 || wr_q[i] !== e[i]) begin
        miscompares++;
        $display("FAIL wrap_word%0d: got %h want %h", i, (wr_q.size() > i) ? wr_q[i] : 8'h00, e[i]);
      end
    end
  endtask

  task automatic test_corrupt();
    run_burst(8, 8'h00, 5, 0);
    vectors++;
    if (err_count !== LW'(1) || obs_done_count != 1) begin
      miscompares++;
      $display("FAIL corrupt: got err=%0d done_pulses=%0d want 1 1", err_count, obs_done_count);
    end
  endtask

  task automatic test_overflow();
    logic [N-1:0] s;
    s = 8'h30;
    run_burst(6, s, -1, 4);
    vectors++;
    if (wr_q.size() != 4 || obs_sr_count != 0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_shape: got cycles=%0d start_reads=%0d overflow=%b want 4 0 1",
               wr_q.size(), obs_sr_count, overflow);
    end else begin
      vectors++;
      if (wr_q[2] !== 8'h32 || wr_q[3] !== 8'h32) begin
        miscompares++;
        $display("FAIL overflow_hold: got %h %h want 32 32", wr_q[2], wr_q[3]);
      end
    end
    run_burst(3, 8'h50, -1, 1);
  endtask

  task automatic test_zero_and_reset();
    int dones;
    run_burst(0, 8'h44, -1, 0);
    vectors++;
    if (obs_done_cycle != 1 || wr_q.size() != 0 || obs_sr_count != 0) begin
      miscompares++;
      $display("FAIL zero_len: got done_cycle=%0d words=%0d start_reads=%0d want 1 0 0",
               obs_done_cycle, wr_q.size(), obs_sr_count);
    end
    cmd_valid = 1'b1;
    cmd_len   = LW'(10);
    cmd_seed  = 8'h40;
    @(posedge clock); #2;
    cmd_valid = 1'b0;
    repeat (5) begin
      @(posedge clock); #2;
    end
    vectors++;
    if (datain !== 8'h44) begin
      miscompares++;
      $display("FAIL mid_word4: got %h want 44", datain);
    end
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    last_data = '0;
    vectors++;
    if ({start, stop, start_read, done, overflow, cmd_ready} !== 6'b000001 || datain !== '0 || err_count !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got strobes=%b datain=%h err=%0d want 000001 00 0",
               {start, stop, start_read, done, overflow, cmd_ready}, datain, err_count);
    end
    dones = 0;
    repeat (30) begin
      @(posedge clock); #2;
      if (done) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL mid_reset_done: got %0d done pulses want 0", dones);
    end
    run_burst(2, 8'hA0, -1, 0);
  endtask

  task automatic test_back_to_back();
    int len, flip, ab;
    for (int i = 0; i < 30; i++) begin
      len  = $urandom_range(0, 24);
      flip = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len)) : -1;
      ab   = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
      run_burst(len, N'($urandom), flip, ab);
    end
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_len    = '0;
    cmd_seed   = '0;
    buff_full  = 1'b0;
    buff_empty = 1'b0;
    test_reset();
    test_basic();
    test_single_wrap();
    test_corrupt();
    test_overflow();
    test_zero_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
